// File: rtl/tile_renderer_pkg.sv
// Shared tile-map definitions: tile codes, palette colours, map size.
// Used by the renderer and by the robot controller that writes the map.
// Pure constants and a palette lookup; no state.
package tile_renderer_pkg;

   localparam int MAP_CELLS = 300;

   localparam logic [2:0] TILE_EMPTY   = 3'd0;
   localparam logic [2:0] TILE_WALL    = 3'd1;
   localparam logic [2:0] TILE_DIRT    = 3'd2;
   localparam logic [2:0] TILE_CLEANED = 3'd3;

   localparam logic [23:0] RGB_EMPTY   = 24'h000000;
   localparam logic [23:0] RGB_WALL    = 24'h808080;
   localparam logic [23:0] RGB_DIRT    = 24'h8B4513;
   localparam logic [23:0] RGB_CLEANED = 24'h87CEEB;
   localparam logic [23:0] RGB_ERROR   = 24'hFF00FF;
   localparam logic [23:0] RGB_ROBOT   = 24'hFFFF00;

   typedef enum logic {ST_CLEAR, ST_RUN} ctrl_state_t;

   // Codes 4..7 are never written by a healthy controller; show them loudly.
   function automatic logic [23:0] tile_rgb(input logic [2:0] code);
      case (code)
         TILE_EMPTY:   tile_rgb = RGB_EMPTY;
         TILE_WALL:    tile_rgb = RGB_WALL;
         TILE_DIRT:    tile_rgb = RGB_DIRT;
         TILE_CLEANED: tile_rgb = RGB_CLEANED;
         default:      tile_rgb = RGB_ERROR;
      endcase
   endfunction

endpackage

// File: rtl/tile_map_ram.sv
// 300 x 3-bit tile map, one write port and one registered read port.
// Read latency 1 clock; a same-cycle read of the written index returns old data.
// Out-of-range indices: writes dropped, reads return the empty tile.
module tile_map_ram
   import tile_renderer_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_we,
   input  logic [8:0]  i_wr_addr,
   input  logic [2:0]  i_wr_data,
   input  logic [15:0] i_rd_addr,
   output logic [2:0]  o_rd_data
);

   logic [2:0] r_mem [0:MAP_CELLS-1];
   logic [2:0] r_rd_data;

   // Write and read in one block so the read sees the pre-write contents.
   always_ff @(posedge i_clk) begin
      if (i_we && (int'(i_wr_addr) < MAP_CELLS))
         r_mem[i_wr_addr] <= i_wr_data;
      if (int'(i_rd_addr) < MAP_CELLS)
         r_rd_data <= r_mem[i_rd_addr[8:0]];
      else
         r_rd_data <= TILE_EMPTY;
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/tile_renderer.sv
// Renders the tile map plus a robot marker onto the VGA pixel stream.
// Latency 2 clocks from pixel/sync inputs to RGB and delayed syncs.
// No backpressure: free-running pixel pipeline; map writes ignored until clear completes.
module tile_renderer
   import tile_renderer_pkg::*;
#(
   parameter int TILE_SHIFT = 5,
   parameter int MAP_COLS   = 20,
   parameter int MAP_ROWS   = 15
) (
   input  logic       clock_25,
   input  logic       reset_key,
   input  logic       video_on,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic       hs_in,
   input  logic       vs_in,
   input  logic       wr_en,
   input  logic [8:0] wr_addr,
   input  logic [2:0] wr_tile,
   input  logic [4:0] robot_col,
   input  logic [3:0] robot_row,
   output logic       ready,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic [7:0] graph_r,
   output logic [7:0] graph_g,
   output logic [7:0] graph_b
);

   localparam logic [9:0] OFF_MASK = 10'((1 << TILE_SHIFT) - 1);

   ctrl_state_t r_state;
   logic [8:0]  r_clr_cnt;
   logic        r_ready;
   logic [4:0]  r_robot_col;
   logic [3:0]  r_robot_row;
   logic        r_s1_vid, r_s1_ovl, r_hs1, r_vs1, r_hs2, r_vs2;
   logic [23:0] r_rgb;

   logic [15:0] w_row, w_col, w_rd_idx;
   logic [9:0]  w_off_x, w_off_y;
   logic        w_robot_ok, w_hit;
   logic        w_ram_we;
   logic [8:0]  w_ram_waddr;
   logic [2:0]  w_ram_wdata, w_tile;

   // Tile coordinates are kept wide so the index never wraps, even off-screen.
   assign w_row    = 16'(pix_y) >> TILE_SHIFT;
   assign w_col    = 16'(pix_x) >> TILE_SHIFT;
   assign w_rd_idx = (w_row << 4) + (w_row << 2) + w_col;
   assign w_off_x  = pix_x & OFF_MASK;
   assign w_off_y  = pix_y & OFF_MASK;

   // Marker is a 16x16 square centred in the robot's tile; off-map positions hide it.
   assign w_robot_ok = (int'(r_robot_col) < MAP_COLS) && (int'(r_robot_row) < MAP_ROWS);
   assign w_hit      = w_robot_ok
                    && (w_col == 16'(r_robot_col)) && (w_row == 16'(r_robot_row))
                    && (w_off_x >= 10'd8) && (w_off_x <= 10'd23)
                    && (w_off_y >= 10'd8) && (w_off_y <= 10'd23);

   // The clearing sweep owns the write port until the map is fully zeroed.
   assign w_ram_we    = (r_state == ST_CLEAR) || (wr_en && r_ready);
   assign w_ram_waddr = (r_state == ST_CLEAR) ? r_clr_cnt : wr_addr;
   assign w_ram_wdata = (r_state == ST_CLEAR) ? TILE_EMPTY : wr_tile;

   tile_map_ram u_map (
      .i_clk     (clock_25),
      .i_we      (w_ram_we),
      .i_wr_addr (w_ram_waddr),
      .i_wr_data (w_ram_wdata),
      .i_rd_addr (w_rd_idx),
      .o_rd_data (w_tile)
   );

   // Controller: sweep every map cell to empty once, then stay in RUN.
   always_ff @(posedge clock_25 or posedge reset_key) begin
      if (reset_key) begin
         r_state   <= ST_CLEAR;
         r_clr_cnt <= 9'd0;
         r_ready   <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_clr_cnt <= r_clr_cnt + 9'd1;
               if (r_clr_cnt == 9'(MAP_CELLS - 1)) begin
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_RUN;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   // Robot position only updates during vsync so the marker never tears.
   always_ff @(posedge clock_25 or posedge reset_key) begin
      if (reset_key) begin
         r_robot_col <= 5'd31;
         r_robot_row <= 4'd15;
      end else if (!vs_in) begin
         r_robot_col <= robot_col;
         r_robot_row <= robot_row;
      end
   end

   // Stage 1: alongside the map read; a read issued before RUN never reaches the screen.
   always_ff @(posedge clock_25 or posedge reset_key) begin
      if (reset_key) begin
         r_s1_vid <= 1'b0;
         r_s1_ovl <= 1'b0;
         r_hs1    <= 1'b1;
         r_vs1    <= 1'b1;
      end else begin
         r_s1_vid <= video_on && (r_state == ST_RUN);
         r_s1_ovl <= w_hit;
         r_hs1    <= hs_in;
         r_vs1    <= vs_in;
      end
   end

   // Stage 2: palette lookup, overlay and blanking.
   always_ff @(posedge clock_25 or posedge reset_key) begin
      if (reset_key) begin
         r_rgb <= RGB_EMPTY;
         r_hs2 <= 1'b1;
         r_vs2 <= 1'b1;
      end else begin
         if (!r_s1_vid)
            r_rgb <= RGB_EMPTY;
         else if (r_s1_ovl)
            r_rgb <= RGB_ROBOT;
         else
            r_rgb <= tile_rgb(w_tile);
         r_hs2 <= r_hs1;
         r_vs2 <= r_vs1;
      end
   end

   assign ready   = r_ready;
   assign vga_hs  = r_hs2;
   assign vga_vs  = r_vs2;
   assign graph_r = r_rgb[23:16];
   assign graph_g = r_rgb[15:8];
   assign graph_b = r_rgb[7:0];

endmodule

// File: tb/tb_tile_renderer.sv
// Randomized stimulus against a behavioural frame model, plus directed pixel checks.
module tb_tile_renderer;

   logic       clock_25 = 1'b0;
   logic       reset_key = 1'b1;
   logic       video_on = 1'b0;
   logic [9:0] pix_x = '0, pix_y = '0;
   logic       hs_in = 1'b1, vs_in = 1'b1;
   logic       wr_en = 1'b0;
   logic [8:0] wr_addr = '0;
   logic [2:0] wr_tile = '0;
   logic [4:0] robot_col = '0;
   logic [3:0] robot_row = '0;
   logic       ready, vga_hs, vga_vs;
   logic [7:0] graph_r, graph_g, graph_b;

   tile_renderer dut (
      .clock_25 (clock_25), .reset_key (reset_key), .video_on (video_on),
      .pix_x (pix_x), .pix_y (pix_y), .hs_in (hs_in), .vs_in (vs_in),
      .wr_en (wr_en), .wr_addr (wr_addr), .wr_tile (wr_tile),
      .robot_col (robot_col), .robot_row (robot_row),
      .ready (ready), .vga_hs (vga_hs), .vga_vs (vga_vs),
      .graph_r (graph_r), .graph_g (graph_g), .graph_b (graph_b)
   );

   always #20 clock_25 = ~clock_25;

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [23:0] pal(input int code);
      case (code)
         0: pal = {8'd0, 8'd0, 8'd0};
         1: pal = {8'd128, 8'd128, 8'd128};
         2: pal = {8'd139, 8'd69, 8'd19};
         3: pal = {8'd135, 8'd206, 8'd235};
         default: pal = {8'd255, 8'd0, 8'd255};
      endcase
   endfunction

   // ---------------- behavioural model ----------------
   int          m_edges = 0;         // clocks since reset release, saturating at 300
   int          m_sh_col = 31, m_sh_row = 15;
   int          m_mem [300];
   logic [25:0] exp_s1 = {2'b11, 24'd0};
   logic [25:0] exp_out = {2'b11, 24'd0};

   always @(posedge clock_25 or posedge reset_key) begin
      if (reset_key) begin
         m_edges = 0;
         m_sh_col = 31;
         m_sh_row = 15;
         for (int i = 0; i < 300; i++) m_mem[i] = 0;
         exp_s1  = {2'b11, 24'd0};
         exp_out = {2'b11, 24'd0};
      end else begin
         bit run;
         int x, y, idx, tile;
         bit ovl;
         logic [23:0] rgb;
         exp_out = exp_s1;
         run = (m_edges >= 300);
         x = int'(pix_x);
         y = int'(pix_y);
         idx = (y / 32) * 20 + (x / 32);
         tile = (idx < 300) ? m_mem[idx] : 0;
         ovl = (x / 32 == m_sh_col) && (y / 32 == m_sh_row) && (m_sh_col < 20) && (m_sh_row < 15)
               && (x % 32 >= 8) && (x % 32 <= 23) && (y % 32 >= 8) && (y % 32 <= 23);
         if (!(video_on && run)) rgb = 24'd0;
         else if (ovl)           rgb = 24'hFFFF00;
         else                    rgb = pal(tile);
         exp_s1 = {hs_in, vs_in, rgb};
         if (run && wr_en && int'(wr_addr) < 300) m_mem[wr_addr] = int'(wr_tile);
         if (!vs_in) begin
            m_sh_col = int'(robot_col);
            m_sh_row = int'(robot_row);
         end
         if (m_edges < 300) m_edges++;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clock_25) begin
      if (chk_en && !reset_key) begin
         check("model_rgb", {8'd0, graph_r, graph_g, graph_b}, {8'd0, exp_out[23:0]});
         check("model_hs", {31'd0, vga_hs}, {31'd0, exp_out[25]});
         check("model_vs", {31'd0, vga_vs}, {31'd0, exp_out[24]});
         check("model_ready", {31'd0, ready}, {31'd0, m_edges >= 300});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clock_25);
      #1;
   endtask

   task automatic idle();
      video_on = 1'b0; wr_en = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
   endtask

   task automatic wr(input int addr, input int code);
      wr_en = 1'b1; wr_addr = 9'(addr); wr_tile = 3'(code);
      step();
      wr_en = 1'b0;
   endtask

   task automatic show(input int x, input int y);
      video_on = 1'b1; pix_x = 10'(x); pix_y = 10'(y);
      step();
      step();
   endtask

   task automatic pulse_vs();
      vs_in = 1'b0;
      step();
      vs_in = 1'b1;
   endtask

   function automatic logic [31:0] rgb_now();
      rgb_now = {8'd0, graph_r, graph_g, graph_b};
   endfunction

   task automatic rand_inputs();
      int x, y;
      if ($urandom_range(1, 0) == 1) begin
         x = m_sh_col * 32 + int'($urandom_range(31, 0));
         y = m_sh_row * 32 + int'($urandom_range(31, 0));
      end else begin
         x = int'($urandom_range(799, 0));
         y = int'($urandom_range(524, 0));
      end
      if (x > 1023) x = 1023;
      if (y > 1023) y = 1023;
      pix_x = 10'(x);
      pix_y = 10'(y);
      video_on = (x < 640) && (y < 480) && ($urandom_range(7, 0) != 0);
      hs_in = ($urandom_range(7, 0) != 0);
      vs_in = ($urandom_range(15, 0) != 0);
      wr_en = ($urandom_range(3, 0) == 0);
      wr_addr = 9'($urandom_range(310, 0));
      wr_tile = 3'($urandom_range(7, 0));
      if ($urandom_range(15, 0) == 0) begin
         robot_col = 5'($urandom_range(23, 0));
         robot_row = 4'($urandom_range(15, 0));
      end
   endtask

   task automatic wait_ready(input string name, input int expected);
      int n = 0;
      bit seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         step();
         n++;
         if (ready) begin
            seen = 1'b1;
            break;
         end
      end
      check(name, seen ? n : 32'hFFFF_FFFF, expected);
      idle();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      step(); step(); step();
      check("reset_ready", {31'd0, ready}, 0);
      check("reset_hs", {31'd0, vga_hs}, 1);
      check("reset_vs", {31'd0, vga_vs}, 1);
      check("reset_rgb", rgb_now(), 0);
      chk_en = 1'b1;
      reset_key = 1'b0;
      wait_ready("ready_latency", 300);

      // Wall tile at index 21.
      wr(21, 1);
      show(40, 40);
      check("wall_21", rgb_now(), 32'h808080);

      // Sync passes through with exactly two clocks of lag.
      hs_in = 1'b0;
      step();
      hs_in = 1'b1;
      check("hs_lag1", {31'd0, vga_hs}, 1);
      step();
      check("hs_lag2", {31'd0, vga_hs}, 0);
      step();
      check("hs_lag3", {31'd0, vga_hs}, 1);

      // Robot marker in tile (col 2, row 0), which holds the cleaned colour.
      wr(2, 3);
      wr(5, 1);
      robot_col = 5'd2; robot_row = 4'd0;
      pulse_vs();
      show(80, 15);
      check("robot_yellow", rgb_now(), 32'hFFFF00);
      show(65, 15);
      check("robot_edge_x", rgb_now(), 32'h87CEEB);
      show(87, 7);
      check("robot_edge_y", rgb_now(), 32'h87CEEB);
      show(87, 23);
      check("robot_corner", rgb_now(), 32'hFFFF00);

      // Same-cycle write and read of index 5.
      wr_en = 1'b1; wr_addr = 9'd5; wr_tile = 3'd2;
      video_on = 1'b1; pix_x = 10'd170; pix_y = 10'd10;
      step();
      wr_en = 1'b0;
      step();
      check("rbw_old", rgb_now(), 32'h808080);
      step();
      check("rbw_new", rgb_now(), 32'h8B4513);

      // Out-of-range write must not land anywhere.
      wr(300, 7);
      show(10, 10);
      check("oob_idx0", rgb_now(), 0);
      show(140, 70);
      check("oob_idx44", rgb_now(), 0);

      // Robot moves only at the next vsync.
      robot_col = 5'd5; robot_row = 4'd1;
      step();
      show(80, 15);
      check("robot_hold", rgb_now(), 32'hFFFF00);
      show(176, 48);
      check("robot_hold_new", rgb_now(), 0);
      pulse_vs();
      show(176, 48);
      check("robot_moved", rgb_now(), 32'hFFFF00);
      robot_col = 5'd25; robot_row = 4'd0;
      pulse_vs();
      show(80, 15);
      check("robot_off_map", rgb_now(), 32'h87CEEB);
      video_on = 1'b0;
      step();
      check("blank_video_off", rgb_now(), 32'h87CEEB);
      step();
      check("blank_video_off2", rgb_now(), 0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         step();
      end

      // Mid-run reset: the map must be cleared again before anything shows.
      idle();
      reset_key = 1'b1;
      step();
      step();
      check("midreset_ready", {31'd0, ready}, 0);
      reset_key = 1'b0;
      wait_ready("ready_latency_2", 300);
      show(40, 40);
      check("cleared_21", rgb_now(), 0);
      for (int i = 0; i < 1500; i++) begin
         rand_inputs();
         step();
      end
      idle();
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
